if_fetch_unit: RTL

//  Instruction-fetch stage directly downstream of the PC register.
//  - Takes the registered PC, fetches the instruction over a req/ready imem port, and loads the IF/ID pipeline register.
//  - Computes next_pc, which feeds straight back into the PC register. That register loads every cycle with no enable, so stalls are encoded in next_pc.
//  - Absorbs ID stalls, EX redirects (branch/jump) and variable imem latency.

---
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage between the PC register and the IF/ID pipeline register.
// Absorbs ID back-pressure, EX redirects and variable-latency instruction memory.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        ifid_free;
  logic [31:0] pc_plus4;
  logic [31:0] hold_pc4;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc + 32'd4;
  assign hold_pc4    = hold_pc_q + 32'd4;
  assign redirect_pc = {redirect_target[31:2], 2'b00};
  assign ifid_free   = !ifid_valid_q || !stall_id;

  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    drain_addr_d = drain_addr_q;
    next_pc      = pc;
    imem_req     = 1'b0;
    imem_addr    = pc;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          next_pc = pc_plus4;
          if (ifid_free) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
          end else begin
            // ID is stalled on a live instruction: park the new one so the
            // PC can still advance and the same address is never refetched.
            hold_pc_d    = pc;
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end else if (ifid_free) begin
          ifid_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_id) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4;
          state_d      = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ready) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A redirect squashes IF/ID and the hold buffer; an in-flight request
    // must still be completed (and discarded) before fetching the target.
    if (redirect_valid) begin
      next_pc      = redirect_pc;
      ifid_valid_d = 1'b0;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = ifid_pc4_q;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            state_d = S_FETCH;
          end else begin
            drain_addr_d = pc;
            state_d      = S_DRAIN;
          end
        end
        S_DRAIN: state_d = imem_ready ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end

    if (rst) begin
      imem_req = 1'b0;
      next_pc  = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= RESET_PC + 32'd4;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

endmodule
